// File: rtl/i2c_target_regs.sv
// +------------------------------------------------------------------------+
// | i2c_target_regs: oversampled I2C target with a byte register file.     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module i2c_target_regs #(
  parameter logic [6:0] ADDR_BASE = 7'h50,
  parameter int         NUM_REGS  = 16,
  parameter int         PTR_W     = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             a0,
  input  logic             a1,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             busy
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       sr_q, sr_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       host_rdata_q, host_rdata_d;
  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       regs_d [NUM_REGS];
  logic             reg_we;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic       addr_hit;

  assign scl_rise  =  scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q &  scl_h_q;
  // Bus conditions only count when SCL has been high for two samples.
  assign start_det = scl_s2_q & scl_h_q &  sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q &  sda_s2_q;

  assign rx_byte  = {sr_q[6:0], sda_s2_q};
  assign rd_byte  = regs_q[ptr_q];
  assign addr_hit = (sr_q[7:1] == {ADDR_BASE[6:2], a1, a0}) && (sr_q[7:1] != 7'd0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    ptr_d        = ptr_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    wr_strobe_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    reg_we       = 1'b0;
    host_rdata_d = regs_q[host_addr];

    if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && (cnt_q != 4'd8)) begin
            sr_d  = rx_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (state_q == ST_PTR) begin
                ptr_d = rx_byte[PTR_W-1:0];
              end
              if (state_q == ST_WDATA) begin
                reg_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = rx_byte;
                ptr_d       = ptr_q + PTR_W'(1);
              end
            end
          end else if (scl_fall && (cnt_q == 4'd8)) begin
            cnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              if (addr_hit) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end else begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            end else begin
              state_d  = (state_q == ST_PTR) ? ST_PTR_ACK : ST_WDATA_ACK;
              sda_oe_d = 1'b1;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (sr_q[0]) begin
              // Read: first data bit goes out on the edge that ends the ACK.
              state_d  = ST_RDATA;
              sr_d     = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = ST_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state_d  = ST_WDATA;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
          end
        end

        ST_RDATA: begin
          if (scl_rise && (cnt_q != 4'd8)) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = ST_RACK;
              cnt_d    = 4'd0;
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + PTR_W'(1);
            end else if (cnt_q != 4'd0) begin
              sr_d     = {sr_q[6:0], 1'b0};
              sda_oe_d = ~sr_q[6];
            end
          end
        end

        ST_RACK: begin
          if (scl_rise) begin
            cnt_d = 4'd1;
            sr_d  = {7'd0, sda_s2_q};
          end else if (scl_fall && (cnt_q == 4'd1)) begin
            cnt_d = 4'd0;
            if (!sr_q[0]) begin
              state_d  = ST_RDATA;
              sr_d     = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = ST_IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (reg_we) begin
      regs_d[ptr_q] = rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q     <= 1'b1;
      scl_s2_q     <= 1'b1;
      scl_h_q      <= 1'b1;
      sda_s1_q     <= 1'b1;
      sda_s2_q     <= 1'b1;
      sda_h_q      <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      sr_q         <= 8'd0;
      ptr_q        <= '0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'd0;
      host_rdata_q <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'd0;
      end
    end else begin
      scl_s1_q     <= scl_i;
      scl_s2_q     <= scl_s1_q;
      scl_h_q      <= scl_s2_q;
      sda_s1_q     <= sda_i;
      sda_s2_q     <= sda_s1_q;
      sda_h_q      <= sda_s2_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      ptr_q        <= ptr_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      host_rdata_q <= host_rdata_d;
      regs_q       <= regs_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = host_rdata_q;

endmodule

`default_nettype wire

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- Synthesizable I2C target (responder) that answers on the same SDA/SCL/A0/A1 pins the UVM agent drives as initiator.
- Oversamples SCL/SDA on the system clock and decodes START, STOP, address, pointer and data.
- Drives ACK and read data through an open-drain enable and exposes an internal byte register file to the host.
- Used as the reference DUT for agent self-checks and as a drop-in target in SoC benches.

Parameters:
- ADDR_BASE, 7'h50, upper 5 bits form target address bits [6:2]; bits [1:0] come from a1/a0.
- NUM_REGS, 16, register file depth; must be a power of two, 2..256.
- PTR_W, $clog2(NUM_REGS), pointer/address width (derived).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- scl_i  in  1  SCL pad input, asynchronous.
- sda_i  in  1  SDA pad input, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release. Registered.
- a0  in  1  address select bit 0, static.
- a1  in  1  address select bit 1, static.
- wr_strobe  out  1  one-cycle pulse when an I2C write byte commits.
- wr_addr  out  PTR_W  register index of the committed write.
- wr_data  out  8  data of the committed write.
- host_addr  in  PTR_W  host read index.
- host_rdata  out  8  regs[host_addr], registered, 1-cycle latency.
- busy  out  1  high from addressed START until STOP or abort.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Input conditioning: scl_i/sda_i pass a 2-flop synchronizer plus a 1-flop history for edge detection (3-clk pad-to-event latency). Bus timing contract: SCL high and low phases each ≥ 4 clk.
- Bus events:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - SDA is sampled on the SCL rising edge. sda_oe changes only on the clk after a detected SCL falling edge.
- Reset: sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, host_rdata=0, busy=0, pointer=0, all regs=0, state=IDLE.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- IDLE --START--> ADDR: shift 8 bits MSB first.
- ADDR: compare byte[7:1] with {ADDR_BASE[6:2],a1,a0}.
  - Mismatch → IGNORE (sda_oe stays 0).
  - Match → ADDR_ACK: assert sda_oe after the 8th SCL fall; release after the 9th SCL fall. busy=1.
- After ADDR_ACK:
  - R/W=0 → PTR.
  - R/W=1 → RDATA; the first data bit is driven on the same 9th SCL fall that releases the ACK.
- PTR: 8 bits received; pointer := byte[PTR_W-1:0] (upper bits ignored); ACK → WDATA.
- WDATA: 8 bits received; ACK always.
  - In the cycle the 8th bit is sampled: wr_strobe=1, wr_addr=pointer, wr_data=byte, regs[pointer]=byte.
  - Then pointer+1 mod NUM_REGS (wraps); → WDATA_ACK → WDATA.
- RDATA: shift regs[pointer] MSB first; sda_oe = ~bit. After the 8th bit: release SDA, pointer+1 (wraps) → RACK.
- RACK: sample the initiator's bit on SCL rise.
  - 0 (ACK) → RDATA, next byte loaded at the 9th SCL fall.
  - 1 (NACK) → IGNORE, sda_oe=0.
- START or STOP in any state (mid-byte included) aborts:
  - sda_oe=0 in the same cycle as detection; shift count cleared.
  - START → ADDR (repeated start); STOP → IDLE with busy=0.
  - A partially received byte is discarded (no wr_strobe).
- IGNORE: leaves only on START/STOP.
- Pointer persists across transactions; a write of only the pointer byte then repeated START+read returns regs[ptr].
- General call (address 0) is not supported (treated as mismatch).
- host_rdata reads regs after the write in the same cycle (shows the new value one cycle after wr_strobe when host_addr matches).
- rst asserted mid-transfer: all state to reset values next clk; SDA released.

Test Plan:
- a1a0=01, write S A2 03 5A C3 P → ACK on all 3 bytes; two wr_strobe pulses (addr 3/5A, addr 4/C3); host_rdata(3)=5A, host_rdata(4)=C3; busy low after STOP.
- Preload regs[3]=5A, regs[4]=C3; S A2 03 Sr A3, read 2 bytes (ACK, NACK) P → SDA shows 5A then C3; sda_oe=0 after NACK; pointer ends at 5.
- Address A4 with a1a0=01 → no ACK (SDA high on 9th clock); no wr_strobe; busy stays 0; subsequent valid transfer to A2 works.
- Pointer wrap: S A2 0F 11 22 P (NUM_REGS=16) → regs[15]=11, regs[0]=22.
- STOP after 4 bits of a data byte → no wr_strobe; sda_oe=0; state IDLE; regs unchanged.
- rst pulsed during read byte while driving SDA low → sda_oe=0 next clk; all regs read 00.
